trap_controller: RTL and testbench

- Sequences trap entry and return for the three-stage RV32 pipeline (Fetch, Decode/Execute, Writeback) and its CSR file.
- Synchronises and latches External_Intrpt.
- Picks the highest-priority event at the Execute-stage instruction boundary and kills that instruction.
- Drives the CSR trap-entry and mret-restore strobes, and redirects fetch to mtvec or mepc; then holds one flush cycle before accepting the next event.

---
 rtl/trap_controller_if.sv | 47 ++++
 rtl/trap_controller.sv | 130 +++++++++++++
 tb/tb_trap_controller.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_controller_if.sv
// Pipeline/CSR side-band bundle between the trap controller and the RV32 core.
interface trap_controller_if #(
  parameter int unsigned XLEN = 32
) ();

  // Execute-stage instruction status
  logic            ex_valid;
  logic            ex_stall;
  logic [XLEN-1:0] ex_pc;
  logic            ex_ecall;
  logic            ex_illegal;
  logic            ex_mret;

  // CSR file state
  logic            mstatus_mie;
  logic            mie_meie;
  logic [XLEN-1:0] mtvec_in;
  logic [XLEN-1:0] mepc_in;

  // Controller responses
  logic            irq_pending;
  logic            kill_ex;
  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            trap_enter;
  logic [XLEN-1:0] mepc_out;
  logic [XLEN-1:0] mcause_out;
  logic            mret_restore;

  // Trap controller side
  modport master (
    input  ex_valid, ex_stall, ex_pc, ex_ecall, ex_illegal, ex_mret,
    input  mstatus_mie, mie_meie, mtvec_in, mepc_in,
    output irq_pending, kill_ex, flush, redirect_valid, redirect_pc,
    output trap_enter, mepc_out, mcause_out, mret_restore
  );

  // Pipeline / CSR file side
  modport slave (
    output ex_valid, ex_stall, ex_pc, ex_ecall, ex_illegal, ex_mret,
    output mstatus_mie, mie_meie, mtvec_in, mepc_in,
    input  irq_pending, kill_ex, flush, redirect_valid, redirect_pc,
    input  trap_enter, mepc_out, mcause_out, mret_restore
  );

endinterface

// File: rtl/trap_controller.sv
// Trap entry / mret sequencer for a three-stage RV32 pipeline. Synchronises the
// external interrupt, arbitrates events at the Execute boundary and holds one
// flush cycle after every taken event.
module trap_controller #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              External_Intrpt,
  trap_controller_if.master bus
);

  localparam logic [XLEN-1:0] CauseIllegal = XLEN'(2);
  localparam logic [XLEN-1:0] CauseEcall   = XLEN'(11);
  localparam logic [XLEN-1:0] CauseMext    = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(11);
  localparam logic [XLEN-1:0] VecOffset    = XLEN'(44);  // 4 * cause 11

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   irq_pending_q, irq_pending_d;
  logic                   irq_rise;
  logic                   decide, take_exc, take_irq, take_mret;
  logic [XLEN-1:0]        mtvec_base;

  // Synchronise the async request and keep the previous synchronised level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], External_Intrpt};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign irq_rise   = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign mtvec_base = {bus.mtvec_in[XLEN-1:2], 2'b00};

  // Event arbitration at the Execute boundary: exception > interrupt > mret
  always_comb begin
    decide    = (state_q == StIdle) & bus.ex_valid & ~bus.ex_stall;
    take_exc  = decide & (bus.ex_illegal | bus.ex_ecall);
    take_irq  = decide & ~take_exc & irq_pending_q & bus.mstatus_mie & bus.mie_meie;
    take_mret = decide & ~take_exc & ~take_irq & bus.ex_mret;
  end

  // Sticky pending bit; a new edge beats the clear from a taken interrupt
  always_comb begin
    irq_pending_d = irq_rise | (irq_pending_q & ~take_irq);
  end

  // Pending bit register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_pending_q <= 1'b0;
    end else begin
      irq_pending_q <= irq_pending_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: every taken event costs exactly one flush cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (take_exc || take_irq || take_mret) state_d = StFlush;
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: Mealy decision strobes in IDLE, flush-only in FLUSH, all low in reset
  always_comb begin
    bus.irq_pending    = 1'b0;
    bus.kill_ex        = 1'b0;
    bus.flush          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.trap_enter     = 1'b0;
    bus.mepc_out       = '0;
    bus.mcause_out     = '0;
    bus.mret_restore   = 1'b0;
    if (!rst) begin
      bus.irq_pending = irq_pending_q;
      unique case (state_q)
        StFlush: bus.flush = 1'b1;
        StIdle: begin
          if (take_exc || take_irq) begin
            bus.kill_ex        = 1'b1;
            bus.flush          = 1'b1;
            bus.redirect_valid = 1'b1;
            bus.trap_enter     = 1'b1;
            bus.mepc_out       = bus.ex_pc;
            if (take_exc) begin
              bus.mcause_out = bus.ex_illegal ? CauseIllegal : CauseEcall;
            end else begin
              bus.mcause_out = CauseMext;
            end
            // Only interrupts vector; mode values 2 and 3 fall back to direct
            if (take_irq && (bus.mtvec_in[1:0] == 2'b01)) begin
              bus.redirect_pc = mtvec_base + VecOffset;
            end else begin
              bus.redirect_pc = mtvec_base;
            end
          end else if (take_mret) begin
            bus.kill_ex        = 1'b1;
            bus.flush          = 1'b1;
            bus.redirect_valid = 1'b1;
            bus.mret_restore   = 1'b1;
            bus.redirect_pc    = bus.mepc_in;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios with literal
// expectations plus a randomized run against a behavioural model.
module tb_trap_controller;

  localparam int unsigned XLEN = 32;
  localparam int unsigned SYNC = 2;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic ext_irq = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  trap_controller_if #(.XLEN(XLEN)) bus ();

  trap_controller #(.XLEN(XLEN), .SYNC_STAGES(SYNC)) dut (
    .clk             (clk),
    .rst             (rst),
    .External_Intrpt (ext_irq),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            kill;
    logic            flush;
    logic            rv;
    logic            te;
    logic            mr;
    logic [XLEN-1:0] rpc;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
  } exp_t;

  // Model state: raw samples of the request (index 0 newest), pending bit, flush cycle
  logic [SYNC:0] hist;
  logic          m_pend;
  logic          m_flush;

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic irq_enabled();
    return m_pend && bus.mstatus_mie && bus.mie_meie;
  endfunction

  function automatic logic exc_now();
    return bus.ex_illegal || bus.ex_ecall;
  endfunction

  function automatic logic eligible();
    return !m_flush && bus.ex_valid && !bus.ex_stall;
  endfunction

  // What the controller must do this cycle, straight from the priority rules
  function automatic exp_t model_out();
    exp_t            e;
    logic [XLEN-1:0] base;
    e    = '0;
    base = bus.mtvec_in & ~32'h3;
    if (m_flush) begin
      e.flush = 1'b1;
    end else if (eligible()) begin
      if (exc_now()) begin
        e.te     = 1'b1;
        e.mepc   = bus.ex_pc;
        e.mcause = bus.ex_illegal ? 32'd2 : 32'd11;
        e.rpc    = base;
      end else if (irq_enabled()) begin
        e.te     = 1'b1;
        e.mepc   = bus.ex_pc;
        e.mcause = 32'h8000_000B;
        e.rpc    = (bus.mtvec_in[1:0] == 2'b01) ? base + 32'd44 : base;
      end else if (bus.ex_mret) begin
        e.mr  = 1'b1;
        e.rpc = bus.mepc_in;
      end
      if (e.te || e.mr) begin
        e.kill  = 1'b1;
        e.flush = 1'b1;
        e.rv    = 1'b1;
      end
    end
    return e;
  endfunction

  // Pending rises after the (SYNC+1)th edge that sees a fresh 0->1 on the raw input
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist    <= '0;
      m_pend  <= 1'b0;
      m_flush <= 1'b0;
    end else begin
      hist    <= {hist[SYNC-1:0], ext_irq};
      m_pend  <= (hist[SYNC-1] & ~hist[SYNC]) |
                 (m_pend & ~(eligible() && !exc_now() && irq_enabled()));
      m_flush <= eligible() && (exc_now() || irq_enabled() || bus.ex_mret);
    end
  end

  task automatic compare_cycle();
    exp_t e;
    if (rst) begin
      check("reset_outputs_zero",
            {23'd0, bus.kill_ex, bus.flush, bus.redirect_valid, bus.trap_enter,
             bus.mret_restore, bus.irq_pending, |bus.redirect_pc, |bus.mepc_out,
             |bus.mcause_out}, 32'd0);
    end else begin
      e = model_out();
      check("irq_pending", 32'(bus.irq_pending), 32'(m_pend));
      check("kill_ex", 32'(bus.kill_ex), 32'(e.kill));
      check("flush", 32'(bus.flush), 32'(e.flush));
      check("redirect_valid", 32'(bus.redirect_valid), 32'(e.rv));
      check("trap_enter", 32'(bus.trap_enter), 32'(e.te));
      check("mret_restore", 32'(bus.mret_restore), 32'(e.mr));
      if (e.rv) check("redirect_pc", bus.redirect_pc, e.rpc);
      if (e.te) begin
        check("mepc_out", bus.mepc_out, e.mepc);
        check("mcause_out", bus.mcause_out, e.mcause);
      end
    end
  endtask

  // Compare against the model mid-cycle, away from the active edge
  always @(negedge clk) compare_cycle();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Request held high across three sampling edges (30 ns)
  task automatic pulse_irq();
    ext_irq = 1'b1;
    tick();
    tick();
    tick();
    ext_irq = 1'b0;
  endtask

  task automatic clear_ex();
    bus.ex_valid   = 1'b0;
    bus.ex_stall   = 1'b0;
    bus.ex_ecall   = 1'b0;
    bus.ex_illegal = 1'b0;
    bus.ex_mret    = 1'b0;
  endtask

  initial begin
    clear_ex();
    bus.ex_pc       = '0;
    bus.mstatus_mie = 1'b0;
    bus.mie_meie    = 1'b0;
    bus.mtvec_in    = '0;
    bus.mepc_in     = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    at_neg();
    check("lit_reset_pending", 32'(bus.irq_pending), 32'd0);
    check("lit_reset_flush", 32'(bus.flush), 32'd0);

    // Interrupt, direct mode
    bus.mstatus_mie = 1'b1;
    bus.mie_meie    = 1'b1;
    bus.mtvec_in    = 32'h100;
    bus.ex_pc       = 32'h20;
    bus.ex_valid    = 1'b1;
    tick();
    ext_irq = 1'b1;
    tick();
    tick();
    at_neg();
    check("lit_latency_early", 32'(bus.irq_pending), 32'd0);
    tick();
    ext_irq = 1'b0;
    at_neg();
    check("lit_irq_pending", 32'(bus.irq_pending), 32'd1);
    check("lit_irq_trap_enter", 32'(bus.trap_enter), 32'd1);
    check("lit_irq_mepc", bus.mepc_out, 32'h20);
    check("lit_irq_mcause", bus.mcause_out, 32'h8000_000B);
    check("lit_irq_redirect", bus.redirect_pc, 32'h100);
    tick();
    bus.ex_valid = 1'b0;
    at_neg();
    check("lit_flush_cycle", 32'(bus.flush), 32'd1);
    check("lit_flush_no_trap", 32'(bus.trap_enter), 32'd0);
    check("lit_pending_cleared", 32'(bus.irq_pending), 32'd0);
    tick();

    // Interrupt, vectored mode
    bus.mtvec_in = 32'h101;
    bus.ex_valid = 1'b1;
    pulse_irq();
    at_neg();
    check("lit_vec_redirect", bus.redirect_pc, 32'h12C);
    tick();
    clear_ex();
    tick();

    // Exception beats a pending enabled interrupt; interrupt follows the flush
    bus.mtvec_in = 32'h100;
    pulse_irq();
    bus.ex_valid   = 1'b1;
    bus.ex_illegal = 1'b1;
    bus.ex_pc      = 32'h40;
    at_neg();
    check("lit_illegal_mcause", bus.mcause_out, 32'd2);
    check("lit_illegal_mepc", bus.mepc_out, 32'h40);
    tick();
    bus.ex_illegal = 1'b0;
    bus.ex_pc      = 32'h44;
    at_neg();
    check("lit_exc_keeps_pending", 32'(bus.irq_pending), 32'd1);
    tick();
    at_neg();
    check("lit_deferred_irq", bus.mcause_out, 32'h8000_000B);
    check("lit_deferred_mepc", bus.mepc_out, 32'h44);
    tick();
    clear_ex();
    tick();

    // Masked interrupt stays pending, then waits out a stall
    bus.mstatus_mie = 1'b0;
    bus.ex_valid    = 1'b1;
    bus.ex_pc       = 32'h60;
    pulse_irq();
    tick();
    at_neg();
    check("lit_masked_pending", 32'(bus.irq_pending), 32'd1);
    check("lit_masked_no_trap", 32'(bus.trap_enter), 32'd0);
    bus.mstatus_mie = 1'b1;
    bus.ex_stall    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      at_neg();
      check("lit_stall_no_trap", 32'(bus.trap_enter), 32'd0);
    end
    tick();
    bus.ex_stall = 1'b0;
    at_neg();
    check("lit_after_stall_trap", 32'(bus.trap_enter), 32'd1);
    check("lit_after_stall_mepc", bus.mepc_out, 32'h60);
    tick();
    clear_ex();
    tick();

    // mret with nothing pending
    bus.mepc_in  = 32'h24;
    bus.ex_valid = 1'b1;
    bus.ex_mret  = 1'b1;
    at_neg();
    check("lit_mret_restore", 32'(bus.mret_restore), 32'd1);
    check("lit_mret_redirect", bus.redirect_pc, 32'h24);
    check("lit_mret_no_trap", 32'(bus.trap_enter), 32'd0);
    tick();
    clear_ex();
    at_neg();
    check("lit_mret_flush", 32'(bus.flush), 32'd1);
    tick();

    // Reset during FLUSH with a pending interrupt
    bus.mstatus_mie = 1'b0;
    pulse_irq();
    bus.ex_valid = 1'b1;
    bus.ex_ecall = 1'b1;
    tick();
    clear_ex();
    #2 rst = 1'b1;
    #1;
    check("lit_rst_flush_low", 32'(bus.flush), 32'd0);
    check("lit_rst_pending_low", 32'(bus.irq_pending), 32'd0);
    tick();
    rst = 1'b0;
    bus.mstatus_mie = 1'b1;
    bus.ex_valid    = 1'b1;
    bus.ex_ecall    = 1'b1;
    bus.ex_pc       = 32'h8;
    at_neg();
    check("lit_ecall_mcause", bus.mcause_out, 32'd11);
    check("lit_ecall_mepc", bus.mepc_out, 32'h8);
    tick();
    clear_ex();
    tick();

    // Randomized traffic checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      bus.ex_valid    = ($urandom_range(3) != 0);
      bus.ex_stall    = ($urandom_range(3) == 0);
      bus.ex_ecall    = ($urandom_range(15) == 0);
      bus.ex_illegal  = ($urandom_range(15) == 0);
      bus.ex_mret     = ($urandom_range(7) == 0);
      bus.mstatus_mie = ($urandom_range(3) != 0);
      bus.mie_meie    = ($urandom_range(3) != 0);
      bus.mtvec_in    = $urandom;
      bus.ex_pc       = $urandom & ~32'h3;
      bus.mepc_in     = $urandom & ~32'h3;
      if ($urandom_range(5) == 0) ext_irq = ~ext_irq;
      if ($urandom_range(299) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
